// File: rtl/power_load_array_pkg.sv
// Shared constants and helpers for the synthetic switching-load array.
package power_load_array_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned ACT_W  = 8;

  // Feedback taps at bits 0, 2, 3 and 5 give a maximal-length 16-bit sequence.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [ACT_W-1:0]  ACT_FULL  = 8'hFF;

  function automatic int unsigned cnt_width(input int unsigned num_ch);
    return $clog2(num_ch + 1);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {^(l & LFSR_TAPS), l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/power_load_array_if.sv
// Control/status bundle between the host registers and the load array.
interface power_load_array_if
  import power_load_array_pkg::*;
#(
  parameter int unsigned NUM_CH = 32
);
  localparam int unsigned CNT_W = cnt_width(NUM_CH);

  logic [NUM_CH-1:0] pwr_en_in;
  logic [ACT_W-1:0]  activity;
  logic [NUM_CH-1:0] active_mask;
  logic [CNT_W-1:0]  active_cnt;
  logic              ramp_busy;
  logic [NUM_CH-1:0] dummy_out;

  modport master (
    output pwr_en_in, activity,
    input  active_mask, active_cnt, ramp_busy, dummy_out
  );

  modport slave (
    input  pwr_en_in, activity,
    output active_mask, active_cnt, ramp_busy, dummy_out
  );

endinterface

// File: rtl/power_load_array_cell.sv
// One load channel: free-running LFSR, duty compare, toggle register, parity flop.
module power_load_cell
  import power_load_array_pkg::*;
#(
  parameter int unsigned LOAD_W = 64,
  parameter int unsigned SEED   = 1
) (
  input  logic             clk100m,
  input  logic             rstn,
  input  logic             en,
  input  logic [ACT_W-1:0] activity_q,
  output logic             dummy
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LOAD_W-1:0] load_q;
  logic              toggle_c;

  // Full activity bypasses the compare so 255 means every cycle, not 255/256.
  assign toggle_c = en && ((activity_q == ACT_FULL) || (lfsr_q[ACT_W-1:0] < activity_q));

  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_W'(SEED);
      load_q <= '0;
      dummy  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (toggle_c) begin
        load_q <= ~{load_q[LOAD_W-2:0], lfsr_q[0]};
      end
      dummy <= ^load_q;
    end
  end

endmodule

// File: rtl/power_load_array.sv
// Array of synthetic switching loads with a one-channel-at-a-time ramp sequencer.
module power_load_array
  import power_load_array_pkg::*;
#(
  parameter int unsigned NUM_CH      = 32,
  parameter int unsigned LOAD_W      = 64,
  parameter int unsigned RAMP_CYCLES = 16
) (
  input  logic        clk100m,
  input  logic        rstn,
  power_load_array_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(NUM_CH);
  localparam int unsigned TMR_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RAMP_CYCLES - 1);

  logic [NUM_CH-1:0] target_q;
  logic [ACT_W-1:0]  activity_q;
  logic [NUM_CH-1:0] active_mask_q;
  logic [NUM_CH-1:0] active_mask_d;
  logic [TMR_W-1:0]  timer_q;
  logic [TMR_W-1:0]  timer_d;
  logic [CNT_W-1:0]  active_cnt_q;
  logic              ramp_busy_q;
  logic [NUM_CH-1:0] dummy_w;

  logic              mismatch_c;
  logic [NUM_CH-1:0] diff_c;
  logic [NUM_CH-1:0] low_bit_c;
  logic [CNT_W-1:0]  popcnt_c;

  assign mismatch_c = (target_q != active_mask_q);
  assign diff_c     = target_q ^ active_mask_q;
  // Two's-complement trick isolates the lowest differing channel.
  assign low_bit_c  = diff_c & ((~diff_c) + NUM_CH'(1));

  // Ramp sequencer next state: step one channel toward the target every RAMP_CYCLES.
  always_comb begin
    timer_d       = timer_q;
    active_mask_d = active_mask_q;
    if (!mismatch_c) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      timer_d       = '0;
      active_mask_d = active_mask_q ^ low_bit_c;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_comb begin
    popcnt_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      popcnt_c = popcnt_c + CNT_W'(active_mask_q[i]);
    end
  end

  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      target_q      <= '0;
      activity_q    <= '0;
      active_mask_q <= '0;
      timer_q       <= '0;
      active_cnt_q  <= '0;
      ramp_busy_q   <= 1'b0;
    end else begin
      target_q      <= bus.pwr_en_in;
      activity_q    <= bus.activity;
      active_mask_q <= active_mask_d;
      timer_q       <= timer_d;
      active_cnt_q  <= popcnt_c;
      ramp_busy_q   <= mismatch_c;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    power_load_cell #(
      .LOAD_W (LOAD_W),
      .SEED   (i + 1)
    ) u_cell (
      .clk100m    (clk100m),
      .rstn       (rstn),
      .en         (active_mask_q[i]),
      .activity_q (activity_q),
      .dummy      (dummy_w[i])
    );
  end

  assign bus.active_mask = active_mask_q;
  assign bus.active_cnt  = active_cnt_q;
  assign bus.ramp_busy   = ramp_busy_q;
  assign bus.dummy_out   = dummy_w;

endmodule

// File: tb/tb_power_load_array.sv
// Random and directed checks of two load-array configurations against a behavioural model.
module tb_power_load_array;

  localparam int NA = 8;
  localparam int WA = 16;
  localparam int RA = 4;
  localparam int NB = 32;
  localparam int RB = 1;

  typedef struct {
    logic [31:0] target;
    logic [31:0] mask;
    int          timer;
    logic        busy;
    int          cnt;
  } ramp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  power_load_array_if #(.NUM_CH(NA)) a_if ();
  power_load_array_if #(.NUM_CH(NB)) b_if ();

  power_load_array #(.NUM_CH(NA), .LOAD_W(WA), .RAMP_CYCLES(RA)) u_dut_a (
    .clk100m (clk),
    .rstn    (rstn),
    .bus     (a_if)
  );

  power_load_array #(.NUM_CH(NB), .LOAD_W(8), .RAMP_CYCLES(RB)) u_dut_b (
    .clk100m (clk),
    .rstn    (rstn),
    .bus     (b_if)
  );

  int total = 0;
  int bad = 0;

  ramp_t       ra, rb;
  logic [7:0]  m_act;
  logic [15:0] m_lfsr [NA];
  logic [WA-1:0] m_load [NA];
  logic [NA-1:0] m_dummy;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // One ramp step: after RAMP cycles of disagreement, fix the lowest differing channel.
  function automatic ramp_t ramp_step(input ramp_t s, input logic [31:0] tgt_in, input int r, input int n);
    ramp_t ns;
    bit    differs;
    ns = s;
    differs = (s.target != s.mask);
    ns.busy = differs;
    ns.cnt = $countones(s.mask);
    if (!differs) begin
      ns.timer = 0;
    end else if (s.timer == r - 1) begin
      ns.timer = 0;
      for (int i = 0; i < n; i++) begin
        if (s.target[i] != s.mask[i]) begin
          ns.mask[i] = s.target[i];
          break;
        end
      end
    end else begin
      ns.timer = s.timer + 1;
    end
    ns.target = tgt_in;
    return ns;
  endfunction

  function automatic ramp_t ramp_zero();
    ramp_t z;
    z.target = '0;
    z.mask = '0;
    z.timer = 0;
    z.busy = 1'b0;
    z.cnt = 0;
    return z;
  endfunction

  task automatic model_reset();
    ra = ramp_zero();
    rb = ramp_zero();
    m_act = '0;
    m_dummy = '0;
    for (int i = 0; i < NA; i++) begin
      m_lfsr[i] = 16'(i + 1);
      m_load[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit tog;
    for (int i = 0; i < NA; i++) begin
      tog = ra.mask[i] && ((m_act == 8'hFF) || (int'(m_lfsr[i][7:0]) < int'(m_act)));
      m_dummy[i] = ^m_load[i];
      if (tog) m_load[i] = ~{m_load[i][WA-2:0], m_lfsr[i][0]};
      m_lfsr[i] = lfsr_adv(m_lfsr[i]);
    end
    ra = ramp_step(ra, 32'(a_if.pwr_en_in), RA, NA);
    rb = ramp_step(rb, b_if.pwr_en_in, RB, NB);
    m_act = a_if.activity;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("mask_a", 32'(a_if.active_mask), ra.mask);
    chk("cnt_a", 32'(a_if.active_cnt), 32'(ra.cnt));
    chk("busy_a", 32'(a_if.ramp_busy), 32'(ra.busy));
    chk("dummy_a", 32'(a_if.dummy_out), 32'(m_dummy));
    chk("mask_b", b_if.active_mask, rb.mask);
    chk("cnt_b", 32'(b_if.active_cnt), 32'(rb.cnt));
    chk("busy_b", 32'(b_if.ramp_busy), 32'(rb.busy));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_zero_a", {a_if.active_mask, 4'(a_if.active_cnt), 3'b0, a_if.ramp_busy, a_if.dummy_out}, 32'h0);
    chk("rst_zero_b", b_if.active_mask | b_if.dummy_out, 32'h0);
  endtask

  initial begin
    logic [7:0] prev;
    int         guard;
    logic       d0;

    a_if.pwr_en_in = '0;
    a_if.activity = '0;
    b_if.pwr_en_in = '0;
    b_if.activity = '0;
    model_reset();

    // Reset and seed
    #2;
    async_reset();
    repeat (3) tick();
    chk("lfsr0_seed", 32'(u_dut_a.g_ch[0].u_cell.lfsr_q), 32'h0001);
    chk("lfsr1_seed", 32'(u_dut_a.g_ch[1].u_cell.lfsr_q), 32'h0002);
    rstn = 1'b1;
    tick();
    chk("lfsr0_s1", 32'(u_dut_a.g_ch[0].u_cell.lfsr_q), 32'h8000);
    tick();
    chk("lfsr0_s2", 32'(u_dut_a.g_ch[0].u_cell.lfsr_q), 32'h4000);

    // No enabled channels: nothing switches regardless of activity
    for (int k = 0; k < 1000; k++) begin
      a_if.activity = 8'($urandom);
      b_if.activity = a_if.activity;
      tick();
    end
    chk("quiet_dummy", 32'(a_if.dummy_out), 32'h0);

    // Full ramp up; capture edge is the first tick
    a_if.pwr_en_in = 8'hFF;
    b_if.pwr_en_in = 32'hFFFF_FFFF;
    a_if.activity = 8'($urandom);
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 4) chk("ramp_a_pre", 32'(a_if.active_mask), 32'h00);
      if (k == 5) chk("ramp_a_e4", 32'(a_if.active_mask), 32'h01);
      if (k == 9) chk("ramp_a_e8", 32'(a_if.active_mask), 32'h03);
      if (k == 32) chk("ramp_b_e31", b_if.active_mask, 32'h7FFF_FFFF);
      if (k == 33) begin
        chk("ramp_a_full", 32'(a_if.active_mask), 32'hFF);
        chk("ramp_b_full", b_if.active_mask, 32'hFFFF_FFFF);
        chk("ramp_a_busy_hi", 32'(a_if.ramp_busy), 32'h1);
      end
      if (k == 34) begin
        chk("ramp_a_busy_lo", 32'(a_if.ramp_busy), 32'h0);
        chk("ramp_a_cnt8", 32'(a_if.active_cnt), 32'd8);
      end
    end

    // Mid-ramp retarget from 0x0F to 0x05
    a_if.pwr_en_in = 8'h00;
    guard = 0;
    while (ra.mask != 0 && guard < 200) begin tick(); guard++; end
    chk("drain_timeout", 32'(guard < 200), 32'h1);
    a_if.pwr_en_in = 8'hFF;
    guard = 0;
    while (ra.mask[7:0] != 8'h0F && guard < 200) begin tick(); guard++; end
    chk("reach_0f_timeout", 32'(guard < 200), 32'h1);
    a_if.pwr_en_in = 8'h05;
    prev = a_if.active_mask;
    guard = 0;
    while (a_if.active_mask == prev && guard < 50) begin tick(); guard++; end
    chk("retarget_step1", 32'(a_if.active_mask), 32'h0D);
    chk("retarget_step1_gap", 32'(guard), 32'd4);
    prev = a_if.active_mask;
    guard = 0;
    while (a_if.active_mask == prev && guard < 50) begin tick(); guard++; end
    chk("retarget_step2", 32'(a_if.active_mask), 32'h05);
    repeat (20) tick();
    chk("retarget_final", 32'(a_if.active_mask), 32'h05);

    // Activity extremes with channel 0 only
    a_if.pwr_en_in = 8'h01;
    a_if.activity = 8'd0;
    repeat (40) tick();
    d0 = a_if.dummy_out[0];
    repeat (200) tick();
    chk("act0_frozen", 32'(a_if.dummy_out[0]), 32'(d0));
    a_if.activity = 8'd255;
    repeat (300) tick();
    a_if.activity = 8'd128;
    repeat (2000) tick();

    // Random targets and duty
    for (int s = 0; s < 40; s++) begin
      a_if.pwr_en_in = 8'($urandom);
      b_if.pwr_en_in = $urandom;
      a_if.activity = 8'($urandom);
      repeat ($urandom_range(1, 80)) tick();
    end

    // Reset in the middle of a ramp, then a clean restart
    async_reset();
    a_if.pwr_en_in = 8'hFF;
    b_if.pwr_en_in = 32'hFFFF_FFFF;
    a_if.activity = 8'd255;
    #2;
    rstn = 1'b1;
    repeat (11) tick();
    chk("pre_reset_mask", 32'(a_if.active_mask), 32'h03);
    async_reset();
    repeat (2) tick();
    rstn = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk("restart_e4", 32'(a_if.active_mask), 32'h01);
    repeat (60) tick();
    chk("restart_full", 32'(a_if.active_mask), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
